aes_add_round_key: RTL and testbench

// - AES-128 AddRoundKey stage with an on-the-fly key schedule. Sits directly upstream of SubBytes.
// - Accepts plaintext and cipher key, then emits state^K0 (round 0) to the SubBytes/ShiftRows/MixColumns path.
// - Takes each returned round state, XORs it with the next round key, and emits the result.
// - After round NR the output is the ciphertext.

---
 rtl/aes_add_round_key_pkg.sv | 59 +++++
 rtl/aes_add_round_key_if.sv | 47 ++++
 rtl/aes_add_round_key_key_expand.sv | 49 ++++
 rtl/aes_add_round_key.sv | 133 +++++++++++++
 tb/tb_aes_add_round_key.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_add_round_key_pkg.sv
// Package aes_pkg: shared types, constants and GF(2^8) helpers for the
// AES-128 AddRoundKey block and its key-schedule step.
//   state_t      128-bit AES state / round key, byte0 = [127:120]
//   word_t       32-bit key-schedule word, w0 = [127:96] of a key
//   NR_128       number of rounds for AES-128
//   RCON         round constants for rounds 1..10 (index 0 -> round 1)
//   ark_state_e  AddRoundKey controller states
//   gf_mul       GF(2^8) multiply, modulus x^8+x^4+x^3+x+1
//   sbox_byte    AES S-box evaluated as inverse + affine transform
//   rcon_for     RCON lookup that returns 0 outside the table
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  localparam int unsigned NR_128 = 10;

  localparam logic [7:0] RCON [NR_128] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE,
    OUT,
    WAIT_FB
  } ark_state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0, so the
  // S-box needs no special case. Square-and-multiply, exponent MSB first:
  // 254 = 8'b1111_1110.
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int unsigned i = 0; i < 8; i++) begin
      inv = gf_mul(inv, inv);
      if (i != 7) inv = gf_mul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_for(input logic [3:0] idx);
    return (idx < 4'(NR_128)) ? RCON[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/aes_add_round_key_if.sv
// Interface aes_add_round_key_if: the three handshake channels of the
// AddRoundKey block.
//   in_*   plaintext + cipher key offered to the block
//   fb_*   round state returned from the SubBytes/ShiftRows/MixColumns path
//   out_*  state XOR round key, with round index and final flag
// Modports:
//   slave   the AddRoundKey block itself
//   master  the surrounding environment (source, round datapath, sink)
interface aes_add_round_key_if #(
  parameter int unsigned ROUND_W = 4
);
  import aes_pkg::*;

  logic               in_valid;
  logic               in_ready;
  state_t             in_state;
  state_t             in_key;

  logic               fb_valid;
  logic               fb_ready;
  state_t             fb_state;

  logic               out_valid;
  logic               out_ready;
  state_t             out_state;
  logic [ROUND_W-1:0] out_round;
  logic               out_final;

  modport slave (
    input  in_valid, in_state, in_key,
    output in_ready,
    input  fb_valid, fb_state,
    output fb_ready,
    output out_valid, out_state, out_round, out_final,
    input  out_ready
  );

  modport master (
    output in_valid, in_state, in_key,
    input  in_ready,
    output fb_valid, fb_state,
    input  fb_ready,
    input  out_valid, out_state, out_round, out_final,
    output out_ready
  );

endinterface

// File: rtl/aes_add_round_key_key_expand.sv
// AES-128 key-schedule helpers (combinational).
//   aes_sbox             i_byte -> o_byte, one S-box lookup
//   aes_key_expand_step  i_key_in (round key Kr), i_rcon (rcon of round r+1)
//                        -> o_key_out (round key Kr+1)
// expand: t = SubWord(RotWord(w3)) ^ {rcon,24'h0};
//         w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = sbox_byte(i_byte);

endmodule

module aes_key_expand_step
  import aes_pkg::*;
(
  input  state_t     i_key_in,
  input  logic [7:0] i_rcon,
  output state_t     o_key_out
);

  word_t w_w0, w_w1, w_w2, w_w3;
  word_t w_rot, w_sub, w_t;
  word_t w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = i_key_in;

  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  assign w_t  = w_sub ^ {i_rcon, 24'h0};
  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign o_key_out = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_add_round_key.sv
// aes_add_round_key: AES-128 AddRoundKey stage with on-the-fly key schedule.
// Accepts plaintext+key, emits state^K0 (round 0), then for each returned
// round state emits fb_state^K(r+1); the round-NR output is the ciphertext.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   aes_add_round_key_if.slave (in_*, fb_*, out_* channels)
// Parameters:
//   NR       number of rounds (AES-128 only: 10)
//   ROUND_W  width of out_round, must hold NR
// Build option:
//   AES_KEY_ZEROIZE_EN  when defined, key_reg is wiped in the cycle the final
//                       output is accepted and out_state one cycle later;
//                       otherwise both retain their last values in IDLE.
module aes_add_round_key
  import aes_pkg::*;
#(
  parameter int unsigned NR      = NR_128,
  parameter int unsigned ROUND_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  aes_add_round_key_if.slave bus
);

  ark_state_e         r_state;
  logic               r_in_ready;
  logic               r_fb_ready;
  logic               r_out_valid;
  logic               r_out_final;
  state_t             r_key_reg;
  state_t             r_out_state;
  logic [ROUND_W-1:0] r_round;

  logic [ROUND_W-1:0] w_round_inc;
  logic [7:0]         w_rcon;
  state_t             w_key_next;

`ifdef AES_KEY_ZEROIZE_EN
  logic               r_wipe_pending;
`endif

  assign w_round_inc = r_round + 1'b1;
  // Key for round r+1 is derived from Kr with rcon[r+1] (table index r).
  assign w_rcon      = rcon_for(r_round[3:0]);

  aes_key_expand_step u_key_expand (
    .i_key_in  (r_key_reg),
    .i_rcon    (w_rcon),
    .o_key_out (w_key_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_fb_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_final <= 1'b0;
      r_key_reg   <= '0;
      r_out_state <= '0;
      r_round     <= '0;
`ifdef AES_KEY_ZEROIZE_EN
      r_wipe_pending <= 1'b0;
`endif
    end else begin
`ifdef AES_KEY_ZEROIZE_EN
      // Delayed out_state wipe; a block loaded in the same cycle overrides it
      // below because its assignment comes later.
      if (r_wipe_pending) begin
        r_out_state    <= '0;
        r_wipe_pending <= 1'b0;
      end
`endif
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_key_reg   <= bus.in_key;
            r_out_state <= bus.in_state ^ bus.in_key;
            r_round     <= '0;
            r_out_final <= 1'b0;
            r_state     <= OUT;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_final <= 1'b0;
            if (r_round == ROUND_W'(NR)) begin
              r_state    <= IDLE;
              r_in_ready <= 1'b1;
`ifdef AES_KEY_ZEROIZE_EN
              r_key_reg      <= '0;
              r_wipe_pending <= 1'b1;
`endif
            end else begin
              r_state    <= WAIT_FB;
              r_fb_ready <= 1'b1;
            end
          end
        end
        WAIT_FB: begin
          if (bus.fb_valid) begin
            r_key_reg   <= w_key_next;
            r_out_state <= bus.fb_state ^ w_key_next;
            r_round     <= w_round_inc;
            r_out_final <= (w_round_inc == ROUND_W'(NR));
            r_state     <= OUT;
            r_fb_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_fb_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_out_final <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.fb_ready  = r_fb_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_state = r_out_state;
  assign bus.out_round = r_round;
  assign bus.out_final = r_out_final;

endmodule

// File: tb/tb_aes_add_round_key.sv
// Testbench for aes_add_round_key: FIPS-197 vectors run through a full AES
// round model, hand-written stall / reset-abort / known-answer sequences, and
// randomized blocks with arbitrary feedback states. Reference key schedule
// and S-box are built independently (log/antilog tables, xtime rcon).
// Honours AES_KEY_ZEROIZE_EN the same way the design does.
module tb_aes_add_round_key;

  typedef logic [127:0] blk_t;

  typedef struct {
    blk_t key;
    blk_t pt;
    blk_t r0;
    blk_t ct;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_add_round_key_if #(.ROUND_W(4)) bus ();

  aes_add_round_key #(.NR(10), .ROUND_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] sb [256];
  blk_t       rk [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from exp/log tables of generator 3, then the affine transform.
  task automatic build_sbox();
    logic [7:0] ex [255];
    int         lg [256];
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = i;
      p = p ^ xt(p);
    end
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand_key(input blk_t key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // SubBytes, ShiftRows and (except in the last round) MixColumns.
  function automatic blk_t aes_round(input blk_t s, input bit last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    blk_t       res;
    for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        b[row + 4*c] = a[row + 4*((c + row) % 4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        logic [7:0] x0, x1, x2, x3;
        x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
        b[4*c]   = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
        b[4*c+1] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
        b[4*c+2] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
        b[4*c+3] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = b[i];
    return res;
  endfunction

  function automatic blk_t rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One block through the DUT. stall_at: round whose output is held 5 cycles
  // with stray in_valid/fb_valid. abort_at: round after whose accept rst is
  // pulsed in WAIT_FB. real_aes: feed true AES rounds, else random states.
  task automatic run_block(input blk_t key, input blk_t pt, input bit real_aes,
                           input int stall_at, input int abort_at,
                           output blk_t first_out, output blk_t last_out);
    blk_t cur, fb;
    int   n;
    expand_key(key);
    first_out = '0;
    last_out  = '0;
    check("in_ready_idle", 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1;
    bus.in_state = pt;
    bus.in_key   = key;
    tick();
    bus.in_valid = 1'b0;
    bus.in_state = rand_blk();
    bus.in_key   = rand_blk();
    cur = pt ^ rk[0];
    for (int r = 0; r <= 10; r++) begin
      check("out_valid", 128'(bus.out_valid), 128'(1));
      check("out_round", 128'(bus.out_round), 128'(r));
      check("out_final", 128'(bus.out_final), 128'(r == 10));
      check("out_state", bus.out_state, cur);
      if (r == 0) first_out = bus.out_state;
      if (r == stall_at) begin
        bus.in_valid = 1'b1;
        bus.fb_valid = 1'b1;
        bus.fb_state = rand_blk();
        for (int k = 0; k < 5; k++) begin
          tick();
          check("stall_state", bus.out_state, cur);
          check("stall_round", 128'(bus.out_round), 128'(r));
          check("stall_fb_ready", 128'(bus.fb_ready), 128'(0));
          check("stall_in_ready", 128'(bus.in_ready), 128'(0));
          check("stall_out_valid", 128'(bus.out_valid), 128'(1));
        end
        bus.in_valid = 1'b0;
        bus.fb_valid = 1'b0;
      end else begin
        n = $urandom_range(0, 2);
        repeat (n) begin
          tick();
          check("hold_state", bus.out_state, cur);
        end
      end
      bus.out_ready = 1'b1;
      if (r == 10) begin
        // A stray offer in the final-accept cycle must not be taken.
        bus.in_valid = 1'b1;
        bus.in_state = ~pt;
        bus.in_key   = ~key;
      end
      tick();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      if (r == 10) begin
        last_out = cur;
        check("post_final_out_valid", 128'(bus.out_valid), 128'(0));
        check("post_final_in_ready", 128'(bus.in_ready), 128'(1));
`ifdef AES_KEY_ZEROIZE_EN
        check("zeroize_key", dut.r_key_reg, 128'(0));
        check("zeroize_state_delay", bus.out_state, cur);
        tick();
        check("zeroize_state", bus.out_state, 128'(0));
`else
        check("retain_state", bus.out_state, cur);
        tick();
        check("retain_state2", bus.out_state, cur);
`endif
        return;
      end
      check("wait_fb_ready", 128'(bus.fb_ready), 128'(1));
      check("wait_out_valid", 128'(bus.out_valid), 128'(0));
      if (r == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 128'(bus.in_ready), 128'(1));
        check("abort_out_valid", 128'(bus.out_valid), 128'(0));
        check("abort_fb_ready", 128'(bus.fb_ready), 128'(0));
        tick();
        check("abort_out_valid2", 128'(bus.out_valid), 128'(0));
        return;
      end
      n = $urandom_range(0, 2);
      repeat (n) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        tick();
        check("fb_wait_ready", 128'(bus.fb_ready), 128'(1));
        check("fb_wait_out_valid", 128'(bus.out_valid), 128'(0));
      end
      bus.in_valid = 1'b0;
      fb = real_aes ? aes_round(cur, r == 9) : rand_blk();
      bus.fb_valid = 1'b1;
      bus.fb_state = fb;
      tick();
      bus.fb_valid = 1'b0;
      bus.fb_state = rand_blk();
      cur = fb ^ rk[r+1];
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [2];
    blk_t f, l;

    tbl[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
               pt:  128'h3243f6a8885a308d313198a2e0370734,
               r0:  128'h193de3bea0f4e22b9ac68d2ae9f84808,
               ct:  128'h3925841d02dc09fbdc118597196a0b32};
    tbl[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
               pt:  128'h00112233445566778899aabbccddeeff,
               r0:  128'h00102030405060708090a0b0c0d0e0f0,
               ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};

    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_key    = '0;
    bus.fb_valid  = 1'b0;
    bus.fb_state  = '0;
    bus.out_ready = 1'b0;
    build_sbox();

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_fb_ready", 128'(bus.fb_ready), 128'(0));
    check("rst_out_state", bus.out_state, 128'(0));
    check("rst_out_round", 128'(bus.out_round), 128'(0));
    check("rst_out_final", 128'(bus.out_final), 128'(0));

    // Known answer: round 0 and K1 with an all-zero feedback state.
    bus.in_valid = 1'b1;
    bus.in_state = tbl[0].pt;
    bus.in_key   = tbl[0].key;
    tick();
    bus.in_valid = 1'b0;
    check("kat_r0_state", bus.out_state, tbl[0].r0);
    check("kat_r0_round", 128'(bus.out_round), 128'(0));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.fb_valid = 1'b1;
    bus.fb_state = '0;
    tick();
    bus.fb_valid = 1'b0;
    check("kat_k1_state", bus.out_state, 128'ha0fafe1788542cb123a339392a6c7605);
    check("kat_k1_round", 128'(bus.out_round), 128'(1));
    check("kat_k1_final", 128'(bus.out_final), 128'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("kat_rst_state", bus.out_state, 128'(0));
    check("kat_rst_valid", 128'(bus.out_valid), 128'(0));

    // FIPS-197 vectors; the first one also holds the round-3 output.
    for (int i = 0; i < 2; i++) begin
      run_block(tbl[i].key, tbl[i].pt, 1'b1, (i == 0) ? 3 : -1, -1, f, l);
      check("tbl_round0", f, tbl[i].r0);
      check("tbl_cipher", l, tbl[i].ct);
    end

    // Abort in WAIT_FB at round 5, then a clean block from round 0.
    run_block(tbl[1].key, tbl[1].pt, 1'b1, -1, 5, f, l);
    run_block(tbl[0].key, tbl[0].pt, 1'b1, -1, -1, f, l);
    check("after_abort_round0", f, tbl[0].r0);
    check("after_abort_cipher", l, tbl[0].ct);

    // Randomized keys, plaintexts, feedback states and handshake gaps.
    for (int b = 0; b < 20; b++) begin
      run_block(rand_blk(), rand_blk(), 1'(b % 4 == 0), -1, -1, f, l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
